// File: rtl/muldiv_hilo_if.sv
// rtl/muldiv_hilo_if.sv - request/result bundle between execute stage and the HI/LO multiply-divide unit
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, rs_val, rt_val,
    input  busy, done, illegal, hi, lo
  );

  modport slave (
    input  start, funct, rs_val, rt_val,
    output busy, done, illegal, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative radix-2 multiply/divide unit owning the HI/LO register pair
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_hilo_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opb;      // mul: multiplicand magnitude; div: divisor magnitude
  logic               is_div;
  logic               sign_q;
  logic               sign_r;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               illegal_r;

  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand decode and one shift-add / restoring-divide step on the accumulator
  always_comb begin
    // even funct codes of the MUL/DIV group are the signed variants
    op_signed = ~bus.funct[0];
    op_div    = bus.funct[1];
    rs_abs    = (op_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    rt_abs    = (op_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

    // multiply: add multiplicand when the LSB of the multiplier is set, then shift right with carry
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});

    // divide: shift left one bit; the trial remainder needs WIDTH+1 bits before the subtract
    div_trial    = acc[2*WIDTH-1:WIDTH-1];
    div_ge       = (div_trial >= {1'b0, opb});
    div_sub      = div_trial[WIDTH-1:0] - opb;
    div_rem_next = div_ge ? div_sub : div_trial[WIDTH-1:0];

    if (is_div) begin
      acc_step = {div_rem_next, acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    prod_fix = sign_q ? -acc : acc;
    quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM, iteration datapath and HI/LO register updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      opb       <= '0;
      is_div    <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      cnt       <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.funct)
              F_MTHI: hi_r <= bus.rs_val;
              F_MTLO: lo_r <= bus.rs_val;
              F_MFHI, F_MFLO: ;
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                is_div <= op_div;
                sign_q <= op_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                sign_r <= op_signed & bus.rs_val[WIDTH-1];
                if (op_div) begin
                  acc <= {{WIDTH{1'b0}}, rs_abs};
                  opb <= rt_abs;
                end else begin
                  acc <= {{WIDTH{1'b0}}, rt_abs};
                  opb <= rs_abs;
                end
                cnt    <= CW'(WIDTH - 1);
                busy_r <= 1'b1;
                state  <= S_CALC;
              end
              default: illegal_r <= 1'b1;
            endcase
          end
        end
        S_CALC: begin
          acc <= acc_step;
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.illegal = illegal_r;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - self-checking bench for muldiv_hilo against an arithmetic reference model
module tb_muldiv_hilo;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk;
  logic rst;

  muldiv_hilo_if #(.WIDTH(W)) bus ();

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain signed/unsigned arithmetic, packed as {hi, lo}
  function automatic logic [2*W-1:0] ref_result(input logic [5:0] f, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      F_MULT:  return sa * sb;
      F_MULTU: return ua * ub;
      F_DIV: begin
        if (b == '0) return {a, (sa < 0) ? 32'd1 : {W{1'b1}}};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[W-1:0], sq[W-1:0]};
      end
      default: begin
        if (b == '0) return {a, {W{1'b1}}};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[W-1:0], uq[W-1:0]};
      end
    endcase
  endfunction

  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  bit m_busy, m_done, m_ill;
  int m_left;

  // Cycle-level model: an op is a countdown followed by a result write
  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_ill = 0; m_left = 0;
    end else begin
      m_done = 0;
      m_ill  = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1; m_busy = 0;
        end
      end else if (bus.start) begin
        case (bus.funct)
          F_MTHI: m_hi = bus.rs_val;
          F_MTLO: m_lo = bus.rs_val;
          F_MFHI, F_MFLO: ;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            {p_hi, p_lo} = ref_result(bus.funct, bus.rs_val, bus.rt_val);
            m_busy = 1;
            m_left = W + 1;
          end
          default: m_ill = 1;
        endcase
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, bus.busy}, {63'd0, m_busy});
      chk("done", {63'd0, bus.done}, {63'd0, m_done});
      chk("illegal", {63'd0, bus.illegal}, {63'd0, m_ill});
      chk("done_and_illegal", {63'd0, bus.done & bus.illegal}, 64'd0);
      chk("hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("lo", {32'd0, bus.lo}, {32'd0, m_lo});
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.funct  = f;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy === 1'b1 && n < 200);
    chk("wait_idle_timeout", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    issue(f, a, b);
    wait_idle();
    chk({name, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    chk({name, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct  = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_hi", {32'd0, bus.hi}, 64'd0);
    chk("reset_lo", {32'd0, bus.lo}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    busy_cnt = 0;
    done_cnt = 0;
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    chk("multu_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("multu_done_pulses", 64'(done_cnt), 64'd1);

    run_op("mult_m3x7", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_m1xm1", F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    run_op("div_m7d2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7d0", F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div_m7d0", F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'h00000001);
    run_op("div_7d0", F_DIV, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_op("divu_100d7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_7dm2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("mult_big", F_MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);

    // move-to-HI while idle: visible next cycle, no busy, no done
    done_cnt = 0;
    issue(F_MTHI, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mthi_hi", {32'd0, bus.hi}, 64'h1234);
    chk("mthi_busy", {63'd0, bus.busy}, 64'd0);
    chk("mthi_done", 64'(done_cnt), 64'd0);
    @(posedge clk);
    #1;
    issue(F_MFLO, 32'h5555, 32'h0);
    issue(F_MTLO, 32'hABCD, 32'd0);
    @(negedge clk);
    chk("mtlo_lo", {32'd0, bus.lo}, 64'hABCD);
    @(posedge clk);
    #1;

    // requests while busy are ignored
    issue(F_MULTU, 32'd3, 32'd5);
    issue(F_MTLO, 32'hDEAD, 32'd0);
    issue(F_MULTU, 32'd9, 32'd9);
    wait_idle();
    chk("busy_ignore_hi", {32'd0, bus.hi}, 64'd0);
    chk("busy_ignore_lo", {32'd0, bus.lo}, 64'd15);
    @(posedge clk);
    #1;

    // reset in the middle of an op discards it
    done_cnt = 0;
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_mid_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, bus.lo}, 64'd0);
    chk("rst_mid_done", 64'(done_cnt), 64'd0);
    @(posedge clk);
    #1;
    busy_cnt = 0;
    run_op("after_rst", F_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
    chk("after_rst_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("after_rst_done_pulses", 64'(done_cnt), 64'd1);

    // unsupported funct: one-cycle illegal pulse, state untouched
    issue(6'b100000, 32'h1111, 32'h2222);
    @(negedge clk);
    chk("illegal_pulse", {63'd0, bus.illegal}, 64'd1);
    chk("illegal_busy", {63'd0, bus.busy}, 64'd0);
    chk("illegal_lo", {32'd0, bus.lo}, 64'd6);
    @(negedge clk);
    chk("illegal_clears", {63'd0, bus.illegal}, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
